// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM serial demultiplexer: steers each frame slot to its own channel output.
module tdm_demux #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                en,
    input  logic                data_in,
    input  logic                sync_in,
    output logic [CHANNELS-1:0] ch_out,
    output logic                frame_valid,
    output logic                locked,
    output logic                sync_err,
    output logic [CNT_W-1:0]    err_count
);

    localparam int SLOT_W = $clog2(CHANNELS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [SLOT_W-1:0]   slot, slot_next;
    logic [CHANNELS-1:0] shadow, shadow_next;
    logic [CHANNELS-1:0] ch_next;
    logic                fv_next;
    logic                err_next;
    logic [CNT_W-1:0]    cnt_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= HUNT;
            slot        <= '0;
            shadow      <= '0;
            ch_out      <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_next;
            slot        <= slot_next;
            shadow      <= shadow_next;
            ch_out      <= ch_next;
            frame_valid <= fv_next;
            sync_err    <= err_next;
            err_count   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        slot_next   = slot;
        shadow_next = shadow;
        ch_next     = ch_out;
        fv_next     = 1'b0;
        err_next    = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (sync_in) begin
                        shadow_next[0] = data_in;
                        slot_next      = SLOT_W'(1);
                        state_next     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot == '0) begin
                        if (sync_in) begin
                            shadow_next[0] = data_in;
                            slot_next      = SLOT_W'(1);
                        end else begin
                            err_next   = 1'b1;
                            slot_next  = '0;
                            state_next = HUNT;
                        end
                    end else if (sync_in) begin
                        // Early marker restarts the frame on this bit as slot 0.
                        err_next       = 1'b1;
                        shadow_next[0] = data_in;
                        slot_next      = SLOT_W'(1);
                    end else begin
                        shadow_next[slot] = data_in;
                        if (slot == LAST_SLOT) begin
                            ch_next   = shadow_next;
                            fv_next   = 1'b1;
                            slot_next = '0;
                        end else begin
                            slot_next = slot + SLOT_W'(1);
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        cnt_next = err_count;
        if (err_next && (err_count != {CNT_W{1'b1}})) begin
            cnt_next = err_count + CNT_W'(1);
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux.
module tb_tdm_demux;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic       data_in = 1'b0;
    logic       sync_in = 1'b0;
    logic [7:0] ch_out;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_count;
    logic [7:0] ch_s;
    logic       fv_s;
    logic       locked_s;
    logic       err_s;
    logic [1:0] cnt_s;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    tdm_demux #(.CHANNELS(8), .CNT_W(8)) dut (
        .clock(clock), .resetn(resetn), .en(en), .data_in(data_in), .sync_in(sync_in),
        .ch_out(ch_out), .frame_valid(frame_valid), .locked(locked),
        .sync_err(sync_err), .err_count(err_count)
    );

    tdm_demux #(.CHANNELS(8), .CNT_W(2)) dut_sat (
        .clock(clock), .resetn(resetn), .en(en), .data_in(data_in), .sync_in(sync_in),
        .ch_out(ch_s), .frame_valid(fv_s), .locked(locked_s),
        .sync_err(err_s), .err_count(cnt_s)
    );

    task automatic tick(input logic e, input logic d, input logic s);
        en = e;
        data_in = d;
        sync_in = s;
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] f);
        for (int i = 0; i < 8; i++) tick(1'b1, f[i], i == 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({ch_out, frame_valid, locked, sync_err, err_count} !== 19'd0) begin
            fails++;
            $display("FAIL reset: got ch=%h fv=%b lk=%b se=%b cnt=%0d expected all 0",
                     ch_out, frame_valid, locked, sync_err, err_count);
        end
    endtask

    task automatic test_lock();
        logic [7:0] f;
        f = 8'b01001101;
        tick(1'b1, f[0], 1'b1);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_first_edge: got locked=%b expected 1", locked);
        end
        for (int i = 1; i < 7; i++) tick(1'b1, f[i], 1'b0);
        tests++;
        if (frame_valid !== 1'b0 || ch_out !== 8'h00) begin
            fails++;
            $display("FAIL lock_early_update: got fv=%b ch=%h expected 0 00", frame_valid, ch_out);
        end
        tick(1'b1, f[7], 1'b0);
        tests++;
        if (frame_valid !== 1'b1 || ch_out !== 8'h4D) begin
            fails++;
            $display("FAIL lock_frame: got fv=%b ch=%h expected 1 4d", frame_valid, ch_out);
        end
        tick(1'b0, 1'b0, 1'b0);
        tests++;
        if (frame_valid !== 1'b0 || err_count !== 8'd0 || ch_out !== 8'h4D) begin
            fails++;
            $display("FAIL lock_pulse: got fv=%b cnt=%0d ch=%h expected 0 0 4d",
                     frame_valid, err_count, ch_out);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] f;
        f = 8'b01001101;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, f[i], i == 0);
            if (i < 7) begin
                tests++;
                if (frame_valid !== 1'b0 || ch_out !== 8'h00) begin
                    fails++;
                    $display("FAIL gapped_slot%0d: got fv=%b ch=%h expected 0 00", i, frame_valid, ch_out);
                end
            end else begin
                tests++;
                if (frame_valid !== 1'b1 || ch_out !== 8'h4D) begin
                    fails++;
                    $display("FAIL gapped_frame: got fv=%b ch=%h expected 1 4d", frame_valid, ch_out);
                end
            end
            // Noise on unstrobed edges must be ignored.
            tick(1'b0, 1'b1, 1'b1);
            tick(1'b0, 1'b1, 1'b1);
        end
        tests++;
        if (frame_valid !== 1'b0 || ch_out !== 8'h4D || sync_err !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL gapped_idle: got fv=%b ch=%h se=%b lk=%b expected 0 4d 0 1",
                     frame_valid, ch_out, sync_err, locked);
        end
    endtask

    task automatic test_early_sync();
        logic [7:0] f;
        f = 8'hA5;
        for (int i = 0; i < 4; i++) tick(1'b1, f[i], i == 0);
        tick(1'b1, 1'b1, 1'b1);
        tests++;
        if (sync_err !== 1'b1 || err_count !== 8'd1 || ch_out !== 8'h4D || locked !== 1'b1) begin
            fails++;
            $display("FAIL early_sync: got se=%b cnt=%0d ch=%h lk=%b expected 1 1 4d 1",
                     sync_err, err_count, ch_out, locked);
        end
        f = 8'h3D;
        for (int i = 1; i < 8; i++) begin
            tick(1'b1, f[i], 1'b0);
            if (i == 1) begin
                tests++;
                if (sync_err !== 1'b0) begin
                    fails++;
                    $display("FAIL early_pulse: got se=%b expected 0", sync_err);
                end
            end
        end
        tests++;
        if (frame_valid !== 1'b1 || ch_out !== 8'h3D || err_count !== 8'd1) begin
            fails++;
            $display("FAIL early_recover: got fv=%b ch=%h cnt=%0d expected 1 3d 1",
                     frame_valid, ch_out, err_count);
        end
    endtask

    task automatic test_missing_sync();
        tick(1'b1, 1'b1, 1'b0);
        tests++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd2 || ch_out !== 8'h3D) begin
            fails++;
            $display("FAIL missing_sync: got se=%b lk=%b cnt=%0d ch=%h expected 1 0 2 3d",
                     sync_err, locked, err_count, ch_out);
        end
        for (int i = 0; i < 5; i++) tick(1'b1, i[0], 1'b0);
        tests++;
        if (sync_err !== 1'b0 || locked !== 1'b0 || err_count !== 8'd2 || ch_out !== 8'h3D) begin
            fails++;
            $display("FAIL hunt_ignore: got se=%b lk=%b cnt=%0d ch=%h expected 0 0 2 3d",
                     sync_err, locked, err_count, ch_out);
        end
        send_frame(8'h97);
        tests++;
        if (frame_valid !== 1'b1 || ch_out !== 8'h97 || locked !== 1'b1) begin
            fails++;
            $display("FAIL relock: got fv=%b ch=%h lk=%b expected 1 97 1", frame_valid, ch_out, locked);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'h01);
            tick(1'b1, 1'b0, 1'b0);
            tests++;
            if (err_count !== 8'(i) || cnt_s !== 2'((i > 3) ? 3 : i)) begin
                fails++;
                $display("FAIL saturation_%0d: got cnt=%0d cnt_sat=%0d expected %0d %0d",
                         i, err_count, cnt_s, i, (i > 3) ? 3 : i);
            end
        end
    endtask

    task automatic test_async_reset();
        send_frame(8'h01);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, i == 0);
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if ({ch_out, frame_valid, locked, sync_err, err_count} !== 19'd0 || cnt_s !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: got ch=%h lk=%b cnt=%0d cnt_sat=%0d expected 00 0 0 0",
                     ch_out, locked, err_count, cnt_s);
        end
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [4];
        pats = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        do_reset();
        for (int fr = 0; fr < 4; fr++) begin
            for (int i = 0; i < 8; i++) begin
                tick(1'b1, pats[fr][i], i == 0);
                tests++;
                if (frame_valid !== (i == 7)) begin
                    fails++;
                    $display("FAIL b2b_fv_f%0d_s%0d: got fv=%b expected %b", fr, i, frame_valid, i == 7);
                end
            end
            tests++;
            if (ch_out !== pats[fr] || sync_err !== 1'b0) begin
                fails++;
                $display("FAIL b2b_ch_f%0d: got ch=%h se=%b expected %h 0", fr, ch_out, sync_err, pats[fr]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_gapped();
        test_early_sync();
        test_missing_sync();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
